// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand select and load-use bubble insertion.
// Drives the ALU A/B/AluOp inputs and carries memory/writeback control into EX.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_AluOp,
  input  logic              id_ALUSrcB,
  input  logic              id_ALUSrcA,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              exm_RegWrite,
  input  logic [4:0]        exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [3:0]        AluOp,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic              hazard_stall
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [3:0]        r_aluop;
  logic              r_alusrca;
  logic              r_alusrcb;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;

  logic              w_hazard;
  logic              w_bubble;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic [XLEN-1:0]   w_b_pre;
  logic              w_is_shift;

  // Load-use: the load in EX produces data too late for the instruction now in decode.
  always_comb begin
    w_hazard = 1'b0;
    if (id_valid && r_valid && r_memread && (r_rd != 5'd0) && !flush) begin
      w_hazard = (id_uses_rs1 && (id_rs1 == r_rd)) || (id_uses_rs2 && (id_rs2 == r_rd));
    end
  end

  assign w_bubble = flush || (!stall && w_hazard);

  // Stage register: flush > stall > load-use bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_aluop    <= '0;
      r_alusrca  <= 1'b0;
      r_alusrcb  <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (!stall) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_aluop    <= id_AluOp;
      r_alusrca  <= id_ALUSrcA;
      r_alusrcb  <= id_ALUSrcB;
      r_regwrite <= id_RegWrite;
      r_memread  <= id_MemRead;
      r_memwrite <= id_MemWrite;
      r_memtoreg <= id_MemtoReg;
    end
  end

  // Forwarding: the younger EX/MEM result beats MEM/WB; x0 always reads its stored value.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exm_RegWrite && (exm_rd != 5'd0) && (exm_rd == r_rs1)) begin
      w_fwd_rs1 = exm_result;
    end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == r_rs1)) begin
      w_fwd_rs1 = wb_data;
    end
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (exm_RegWrite && (exm_rd != 5'd0) && (exm_rd == r_rs2)) begin
      w_fwd_rs2 = exm_result;
    end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == r_rs2)) begin
      w_fwd_rs2 = wb_data;
    end
  end

  assign w_is_shift = (r_aluop == OP_SLL) || (r_aluop == OP_SRL) || (r_aluop == OP_SRA);
  assign w_b_pre    = r_alusrcb ? r_imm : w_fwd_rs2;

  // Shifts only consume the low five bits of B as the shift amount.
  always_comb begin
    B = w_b_pre;
    if (w_is_shift) begin
      B = {{(XLEN-SHAMT_W){1'b0}}, w_b_pre[SHAMT_W-1:0]};
    end
  end

  assign A             = r_alusrca ? r_pc : w_fwd_rs1;
  assign AluOp         = r_aluop;
  assign ex_store_data = w_fwd_rs2;
  assign ex_valid      = r_valid;
  assign ex_RegWrite   = r_regwrite;
  assign ex_MemRead    = r_memread;
  assign ex_MemWrite   = r_memwrite;
  assign ex_MemtoReg   = r_memtoreg;
  assign ex_rd         = r_rd;
  assign ex_pc         = r_pc;
  assign hazard_stall  = w_hazard;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that drives the ALU's `A`, `B` and `AluOp` inputs in the 5-stage RISC-V core. It captures decoded operands and control from decode and forwards results from EX/MEM and MEM/WB into the operands. It detects load-use hazards and inserts a bubble. It honours stall and flush requests from the hazard/branch unit.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold all stage registers (downstream not ready)
- `flush`  in  1  replace stage contents with a bubble (branch/jump taken)
- `id_valid`  in  1  decode slot holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decode operands
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register addresses
- `id_AluOp`  in  4  ALU opcode (ALU encoding)
- `id_ALUSrcB`  in  1  1 selects immediate for B
- `id_ALUSrcA`  in  1  1 selects PC for A
- `id_uses_rs1`, `id_uses_rs2`  in  1  operand actually read
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemtoReg`  in  1  control
- `exm_RegWrite`  in  1, `exm_rd`  in  5, `exm_result`  in  XLEN  EX/MEM forward source
- `wb_RegWrite`  in  1, `wb_rd`  in  5, `wb_data`  in  XLEN  MEM/WB forward source
- `A`, `B`  out  XLEN  ALU operands
- `AluOp`  out  4  ALU opcode
- `ex_store_data`  out  XLEN  forwarded rs2 for stores
- `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg`  out  1
- `ex_rd`  out  5, `ex_pc`  out  XLEN
- `hazard_stall`  out  1  load-use detected; upstream (PC, IF/ID) must hold

## Operation
- Stage register update priority on each rising `clk`: `flush` > `stall` > `hazard_stall` > capture.
  - `flush`: load bubble (`ex_valid`=0, all control bits 0, `AluOp`=0000, data 0).
  - `stall`: hold every register.
  - `hazard_stall`: load bubble. Upstream holds, so the dependent instruction is captured the following cycle.
  - Otherwise capture all `id_*` inputs.
- `hazard_stall` = `id_valid` & `ex_valid` & `ex_MemRead` & `ex_rd`≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)). It is combinational and forced to 0 while `flush` is high.
- Forwarding is combinational from the registered rs1/rs2 values, independently per operand:
  - EX/MEM match (`exm_RegWrite`, `exm_rd`≠0, `exm_rd`==rs) selects `exm_result`.
  - Otherwise a MEM/WB match selects `wb_data`.
  - Otherwise the registered register data is used.
  - x0 is never forwarded.
- Operand A = `ex_pc` if ALUSrcA, else forwarded rs1.
- Operand B = immediate if ALUSrcB, else forwarded rs2.
- `ex_store_data` is always forwarded rs2, regardless of ALUSrcB.
- Shift ops (`AluOp` 1101, 1110, 1000): B output = {27'b0, B[4:0]}, so the shift amount is 0–31.
- No arithmetic on data beyond muxing and masking; widths are all XLEN.

## Timing
- Reset (async, `rst_n`=0): all registered outputs are 0. `A`=`B`=0, `AluOp`=0000, `ex_valid`=0, `hazard_stall`=0. Release is synchronous to the next edge.
- Latency: decode inputs appear at `A`/`B`/`AluOp` one cycle after capture.
- Forward sources affect `A`/`B` in the same cycle (combinational path).
- Load-use costs exactly one bubble cycle. After the bubble, the load sits in MEM/WB and its data reaches the operand via the `wb_data` forward.
- `stall` and `hazard_stall` together: hold wins. The hazard is re-evaluated next cycle.
- `flush` and `stall` together: flush wins and a bubble is loaded.
- Reset mid-operation discards the in-flight instruction with no partial update.

## Test plan
- Reset → after `rst_n` rises, `A`=0, `B`=0, `AluOp`=0000, `ex_valid`=0. Then capture ADD with rs1_data=5, rs2_data=7 → next cycle `A`=5, `B`=7, `AluOp`=0010.
- Double forward: registered rs1=x3. `exm_rd`=3 with `exm_result`=0x11 and `wb_rd`=3 with `wb_data`=0x22 → `A`=0x11. Drop `exm_RegWrite` → `A`=0x22. With rs1=x0 and `exm_rd`=0 → `A`=registered data.
- Load-use: LW x5 in EX, decode ADD x6,x5,x1 with `id_uses_rs1`=1 → `hazard_stall`=1 for one cycle, next cycle `ex_valid`=0. The following cycle ADD is captured and takes `wb_data` for `A`.
- Flush vs stall: both high with a valid instruction in decode → next cycle `ex_valid`=0 and all control 0. `stall` alone → outputs are unchanged for 3 held cycles.
- Shift mask: SLL with `B` source 0x00000123 → `B` output 0x00000003. ADDI with imm=0xFFFFFFFF and ALUSrcB=1 → `B`=0xFFFFFFFF and `ex_store_data`=forwarded rs2.
